rtc_time_set: RTL
=================

# rtc_time_set

Time display/set controller sitting directly upstream of the 6-digit seg7 BCD display stage in the DS1302 RTC demo. In run mode it forwards the RTC's current hour/minute/second as a 24-bit BCD word. In set mode it lets two debounced keys select and increment one field, drives the per-digit blink mask for the selected field, and hands the edited time to the RTC writer through a req/ack handshake.

## Interface
- SET_TIMEOUT, default 500_000_000: cycles without a key press before set mode is abandoned. 10 s at 50 MHz; width 32.
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- key_set  input  1  single-cycle pulse, debounced: enter set mode / advance field
- key_inc  input  1  single-cycle pulse, debounced: increment selected field
- rtc_hour  input  8  current hour from RTC reader, BCD
- rtc_min  input  8  current minute, BCD
- rtc_sec  input  8  current second, BCD
- write_ack  input  1  RTC writer accepted the write
- write_req  output  1  request to write edited time
- write_hour  output  8  BCD hour to write
- write_min  output  8  BCD minute to write
- write_sec  output  8  BCD second to write
- seg_bcd  output  24  display word: [23:16] hour, [15:8] min, [7:0] sec
- seg_blink  output  6  per-digit blink; bit0 = seg_bcd[23:20] … bit5 = seg_bcd[3:0]

## Operation
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- States:
  - RUN: seg_bcd <= {rtc_hour, rtc_min, rtc_sec}; seg_blink = 0.
    - key_set copies rtc_* into edit registers and moves to SET_HOUR.
  - SET_HOUR: seg_blink = 6'b000011.
  - SET_MIN: seg_blink = 6'b001100.
  - SET_SEC: seg_blink = 6'b110000.
  - In each SET state, seg_bcd = {edit_hour, edit_min, edit_sec}.
  - key_set advances SET_HOUR→SET_MIN→SET_SEC→WRITE.
  - WRITE: write_req = 1; write_* hold the edit registers, stable until ack. seg_blink = 0. seg_bcd shows the edit registers.
    - write_ack = 1 moves to RUN. write_req deasserts the next cycle.
- Increment (key_inc in a SET state) uses BCD arithmetic on the selected field only:
  - Hour wraps 23→00. Minute and second wrap 59→00.
  - Ones nibble 9 carries to tens.
  - Any field holding an invalid value wraps to 00 on increment. Invalid means a nibble >9, or a value above the field maximum.
- Edit registers do not track the RTC while in set mode. The display freezes at the edited values.
- Idle timeout, SET states only:
  - A counter clears on every key pulse and on SET entry.
  - When it reaches SET_TIMEOUT-1, the state returns to RUN with no write. Edits are discarded.
- Boundary cases:
  - key_set and key_inc in the same cycle: key_set wins, increment is dropped.
  - Keys in WRITE are ignored. The timeout does not run in WRITE; the block waits indefinitely for ack.
  - write_ack outside WRITE is ignored.
  - write_ack already high on the WRITE entry cycle: it is accepted on the first WRITE cycle.
  - key_inc in RUN is ignored.

## Timing
- All outputs are registered.
- Reset values: state RUN; seg_bcd = 24'h000000; seg_blink = 0; write_req = 0; write_hour, write_min, write_sec = 8'h00; edit registers 0; timeout counter 0.
- RUN: seg_bcd reflects rtc_* one cycle after they change.
- key_set in RUN at cycle N:
  - state is SET_HOUR at N+1;
  - seg_blink = 6'b000011 at N+1;
  - seg_bcd shows the captured time at N+1.
- key_inc at cycle N: the updated field appears on seg_bcd at N+1.
- key_set in SET_SEC at N: write_req = 1 from N+1. write_* are valid at N+1 and held until the ack cycle.
- write_ack at cycle M: write_req = 0 and state RUN at M+1.
- Reset asserted mid-operation, including WRITE: immediate return to the reset values. No partial write is held.

## Structure
- Package rtc_pkg:
  - state enum (RUN, SET_HOUR, SET_MIN, SET_SEC, WRITE);
  - blink mask constants BLINK_HOUR/MIN/SEC;
  - field maxima HOUR_MAX = 8'h23 and MINSEC_MAX = 8'h59.
- Sub-module bcd_field_inc: combinational 8-bit BCD increment with a max input and the wrap/invalid→00 rule. It is instantiated once and muxed by state.

## Test plan
- Reset, then rtc = 12:34:56 → seg_bcd = 24'h123456 one cycle later, seg_blink = 0, write_req = 0.
- Enter set, 11 key_inc in SET_HOUR with rtc hour 8'h15:
  - key_set → seg_blink = 6'b000011;
  - hour 15→…→23→00→02;
  - min and sec are unchanged.
- Minute wrap: key_set twice then key_inc with edit_min = 8'h59 → 8'h00. Second at 8'h09 → 8'h10.
- Full edit to 07:08:09, key_set in SET_SEC → write_req = 1 and write_* = 07/08/09 held stable. Hold write_ack low for 20 cycles, then pulse it → write_req = 0 next cycle, RUN.
- Timeout with SET_TIMEOUT = 16: enter set, increment once, no keys for 16 cycles → RUN, write_req never asserted, seg_bcd tracks rtc again.
- key_set and key_inc in the same cycle in SET_MIN → state SET_SEC, minute unchanged. Reset asserted during WRITE → all outputs at reset values.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC time display/set controller.
// Field maxima are BCD-encoded so they compare directly against edit registers.
package rtc_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_HOUR = 3'd1,
    SET_MIN  = 3'd2,
    SET_SEC  = 3'd3,
    WRITE    = 3'd4
  } state_t;

  localparam logic [5:0] BLINK_HOUR = 6'b000011;
  localparam logic [5:0] BLINK_MIN  = 6'b001100;
  localparam logic [5:0] BLINK_SEC  = 6'b110000;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

endpackage

// File: rtl/rtc_time_set_bcd_field_inc.sv
// Combinational two-digit BCD increment with wrap at i_max.
// A malformed value (nibble above 9, or above i_max) restarts the field at 00.
module bcd_field_inc (
  input  logic [7:0] i_val,
  input  logic [7:0] i_max,
  output logic [7:0] o_val
);

  logic [3:0] w_hi;
  logic [3:0] w_lo;
  logic       w_invalid;

  assign w_hi      = i_val[7:4];
  assign w_lo      = i_val[3:0];
  // Valid BCD keeps numeric order under unsigned compare, so > i_max is safe here.
  assign w_invalid = (w_hi > 4'd9) || (w_lo > 4'd9) || (i_val > i_max);

  always_comb begin
    o_val = {w_hi, w_lo + 4'd1};
    if (w_invalid || (i_val == i_max)) begin
      o_val = 8'h00;
    end else if (w_lo == 4'd9) begin
      o_val = {w_hi + 4'd1, 4'h0};
    end
  end

endmodule

// File: rtl/rtc_time_set.sv
// Time display/set controller in front of the 6-digit BCD display.
// Run mode mirrors the RTC; set mode edits one field at a time and hands the result to the RTC writer.
module rtc_time_set
  import rtc_pkg::*;
#(
  parameter logic [31:0] SET_TIMEOUT = 32'd500_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_set,
  input  logic        key_inc,
  input  logic [7:0]  rtc_hour,
  input  logic [7:0]  rtc_min,
  input  logic [7:0]  rtc_sec,
  input  logic        write_ack,
  output logic        write_req,
  output logic [7:0]  write_hour,
  output logic [7:0]  write_min,
  output logic [7:0]  write_sec,
  output logic [23:0] seg_bcd,
  output logic [5:0]  seg_blink
);

  state_t      r_state, w_state_next;
  logic [7:0]  r_edit_hour, r_edit_min, r_edit_sec;
  logic [7:0]  w_edit_hour_next, w_edit_min_next, w_edit_sec_next;
  logic [31:0] r_tmo_cnt, w_tmo_cnt_next;

  logic [23:0] r_seg_bcd, w_seg_bcd_next;
  logic [5:0]  r_seg_blink, w_seg_blink_next;
  logic        r_write_req, w_write_req_next;
  logic [7:0]  r_write_hour, r_write_min, r_write_sec;
  logic        w_write_load;

  logic [7:0]  w_inc_in, w_inc_max, w_inc_out;

  // Single incrementer shared across fields; the current SET state picks its operand.
  always_comb begin
    w_inc_in  = r_edit_sec;
    w_inc_max = MINSEC_MAX;
    case (r_state)
      SET_HOUR: begin
        w_inc_in  = r_edit_hour;
        w_inc_max = HOUR_MAX;
      end
      SET_MIN:  w_inc_in = r_edit_min;
      default:  ;
    endcase
  end

  bcd_field_inc u_field_inc (
    .i_val (w_inc_in),
    .i_max (w_inc_max),
    .o_val (w_inc_out)
  );

  always_comb begin
    w_state_next     = r_state;
    w_edit_hour_next = r_edit_hour;
    w_edit_min_next  = r_edit_min;
    w_edit_sec_next  = r_edit_sec;
    w_tmo_cnt_next   = 32'd0;

    case (r_state)
      RUN: begin
        if (key_set) begin
          w_edit_hour_next = rtc_hour;
          w_edit_min_next  = rtc_min;
          w_edit_sec_next  = rtc_sec;
          w_state_next     = SET_HOUR;
        end
      end
      SET_HOUR, SET_MIN, SET_SEC: begin
        if (key_set) begin
          // key_set takes priority; a simultaneous key_inc is dropped.
          case (r_state)
            SET_HOUR: w_state_next = SET_MIN;
            SET_MIN:  w_state_next = SET_SEC;
            default:  w_state_next = WRITE;
          endcase
        end else if (key_inc) begin
          case (r_state)
            SET_HOUR: w_edit_hour_next = w_inc_out;
            SET_MIN:  w_edit_min_next  = w_inc_out;
            default:  w_edit_sec_next  = w_inc_out;
          endcase
        end else if (r_tmo_cnt == SET_TIMEOUT - 32'd1) begin
          w_state_next = RUN;
        end else begin
          w_tmo_cnt_next = r_tmo_cnt + 32'd1;
        end
      end
      WRITE: begin
        if (write_ack) begin
          w_state_next = RUN;
        end
      end
      default: w_state_next = RUN;
    endcase
  end

  // Outputs are registered from the next-state view so they change on the same edge as the state.
  always_comb begin
    w_seg_bcd_next   = {w_edit_hour_next, w_edit_min_next, w_edit_sec_next};
    w_seg_blink_next = 6'b000000;
    w_write_req_next = (w_state_next == WRITE);
    w_write_load     = (w_state_next == WRITE) && (r_state != WRITE);
    case (w_state_next)
      RUN:      w_seg_bcd_next   = {rtc_hour, rtc_min, rtc_sec};
      SET_HOUR: w_seg_blink_next = BLINK_HOUR;
      SET_MIN:  w_seg_blink_next = BLINK_MIN;
      SET_SEC:  w_seg_blink_next = BLINK_SEC;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_edit_hour  <= 8'h00;
      r_edit_min   <= 8'h00;
      r_edit_sec   <= 8'h00;
      r_tmo_cnt    <= 32'd0;
      r_seg_bcd    <= 24'h000000;
      r_seg_blink  <= 6'b000000;
      r_write_req  <= 1'b0;
      r_write_hour <= 8'h00;
      r_write_min  <= 8'h00;
      r_write_sec  <= 8'h00;
    end else begin
      r_state      <= w_state_next;
      r_edit_hour  <= w_edit_hour_next;
      r_edit_min   <= w_edit_min_next;
      r_edit_sec   <= w_edit_sec_next;
      r_tmo_cnt    <= w_tmo_cnt_next;
      r_seg_bcd    <= w_seg_bcd_next;
      r_seg_blink  <= w_seg_blink_next;
      r_write_req  <= w_write_req_next;
      if (w_write_load) begin
        r_write_hour <= w_edit_hour_next;
        r_write_min  <= w_edit_min_next;
        r_write_sec  <= w_edit_sec_next;
      end
    end
  end

  assign write_req  = r_write_req;
  assign write_hour = r_write_hour;
  assign write_min  = r_write_min;
  assign write_sec  = r_write_sec;
  assign seg_bcd    = r_seg_bcd;
  assign seg_blink  = r_seg_blink;

endmodule
